// File: rtl/wb_queue_if.sv
// wb_queue_if: groups the producer handshakes and the register-file write-back
// port of the write-back queue.
//   alu_*      ALU result handshake (valid/rd/data in, ready out)
//   mem_*      load result handshake (valid/rd/data in, ready out)
//   wb_o, wb_r_o, result_o   write-back strobe/register/data to the register file
//   pending_o  queue occupancy
// modport slave is the queue side; modport master is the surrounding pipeline.
interface wb_queue_if #(
    parameter int W_RD  = 4,
    parameter int W_OPR = 32,
    parameter int W_CNT = 3
);
    logic             alu_valid_i;
    logic [W_RD-1:0]  alu_rd_i;
    logic [W_OPR-1:0] alu_data_i;
    logic             alu_ready_o;
    logic             mem_valid_i;
    logic [W_RD-1:0]  mem_rd_i;
    logic [W_OPR-1:0] mem_data_i;
    logic             mem_ready_o;
    logic             wb_o;
    logic [W_RD-1:0]  wb_r_o;
    logic [W_OPR-1:0] result_o;
    logic [W_CNT-1:0] pending_o;

    modport slave (
        input  alu_valid_i, alu_rd_i, alu_data_i,
        output alu_ready_o,
        input  mem_valid_i, mem_rd_i, mem_data_i,
        output mem_ready_o,
        output wb_o, wb_r_o, result_o, pending_o
    );

    modport master (
        output alu_valid_i, alu_rd_i, alu_data_i,
        input  alu_ready_o,
        output mem_valid_i, mem_rd_i, mem_data_i,
        input  mem_ready_o,
        input  wb_o, wb_r_o, result_o, pending_o
    );
endinterface

// File: rtl/wb_queue.sv
// wb_queue: in-order write-back collector. Accepts up to two results per cycle
// (ALU and load), buffers them in a DEPTH-entry FIFO and retires one entry per
// cycle onto the register-file write-back port.
//   clk  rising-edge clock
//   rst  asynchronous, active-low reset
//   bus  wb_queue_if.slave: producer handshakes, write-back port, occupancy
module wb_queue #(
    parameter int W_RD  = 4,
    parameter int W_OPR = 32,
    parameter int DEPTH = 4,
    parameter int W_CNT = 3
) (
    input  logic         clk,
    input  logic         rst,
    wb_queue_if.slave    bus
);
    localparam int W_PTR = $clog2(DEPTH);

    logic [W_RD-1:0]  rd_q   [DEPTH];
    logic [W_OPR-1:0] data_q [DEPTH];
    logic [W_PTR-1:0] head_q, head_d;
    logic [W_PTR-1:0] tail_q, tail_d;
    logic [W_CNT-1:0] count_q, count_d;

    logic [W_CNT-1:0] free_w;
    logic             alu_push, mem_push, pop;
    logic [W_PTR-1:0] mem_idx;

    // Readies come from registered occupancy only; the pop of this cycle is
    // not credited, which keeps them off the write-back path.
    assign free_w          = W_CNT'(DEPTH) - count_q;
    assign bus.alu_ready_o = (free_w >= W_CNT'(1));
    // A load that arrives with an ALU result needs room for both entries.
    assign bus.mem_ready_o = bus.alu_valid_i ? (free_w >= W_CNT'(2))
                                             : (free_w >= W_CNT'(1));

    assign alu_push = bus.alu_valid_i & bus.alu_ready_o;
    assign mem_push = bus.mem_valid_i & bus.mem_ready_o;
    assign pop      = (count_q != '0);

    // ALU entry takes the tail slot; the load goes behind it when both arrive.
    assign mem_idx  = tail_q + W_PTR'(alu_push);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) head_d = head_q + W_PTR'(1);
        tail_d  = tail_q + W_PTR'(alu_push) + W_PTR'(mem_push);
        count_d = count_q + W_CNT'(alu_push) + W_CNT'(mem_push) - W_CNT'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset: only slots between head and tail are read.
    always_ff @(posedge clk) begin
        if (alu_push) begin
            rd_q[tail_q]   <= bus.alu_rd_i;
            data_q[tail_q] <= bus.alu_data_i;
        end
        if (mem_push) begin
            rd_q[mem_idx]   <= bus.mem_rd_i;
            data_q[mem_idx] <= bus.mem_data_i;
        end
    end

    // Head entry is masked when empty so the port reads zero after reset.
    assign bus.wb_o      = pop;
    assign bus.wb_r_o    = pop ? rd_q[head_q]   : '0;
    assign bus.result_o  = pop ? data_q[head_q] : '0;
    assign bus.pending_o = count_q;
endmodule

// File: tb/tb_wb_queue.sv
module tb_wb_queue;
    logic clk = 1'b0;
    logic rst;
    int   n_run  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    wb_queue_if #(.W_RD(4), .W_OPR(32), .W_CNT(3)) bus ();

    wb_queue #(.W_RD(4), .W_OPR(32), .DEPTH(4), .W_CNT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [3:0] ard, input logic [31:0] ad,
                         input logic mv, input logic [3:0] mrd, input logic [31:0] md);
        bus.alu_valid_i = av;
        bus.alu_rd_i    = ard;
        bus.alu_data_i  = ad;
        bus.mem_valid_i = mv;
        bus.mem_rd_i    = mrd;
        bus.mem_data_i  = md;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    endtask

    // Advance past the next rising edge; outputs are then settled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wb(input string tag, input logic wb, input logic [3:0] r,
                          input logic [31:0] d, input logic [2:0] p);
        chk({tag, ".wb"},      {31'd0, bus.wb_o},    {31'd0, wb});
        chk({tag, ".wb_r"},    {28'd0, bus.wb_r_o},  {28'd0, r});
        chk({tag, ".result"},  bus.result_o,         d);
        chk({tag, ".pending"}, {29'd0, bus.pending_o}, {29'd0, p});
    endtask

    initial begin
        rst = 1'b0;
        idle();
        chk_wb("rst0", 1'b0, 4'd0, 32'd0, 3'd0);
        step();
        rst = 1'b1;
        #1;
        chk("rst0.alu_rdy", {31'd0, bus.alu_ready_o}, 32'd1);

        // Single ALU result: visible one edge after acceptance, gone the next.
        drive(1'b1, 4'd5, 32'h1234, 1'b0, 4'd0, 32'd0);
        chk("single.alu_rdy", {31'd0, bus.alu_ready_o}, 32'd1);
        step(); idle();
        chk_wb("single.n1", 1'b1, 4'd5, 32'h1234, 3'd1);
        step();
        chk_wb("single.n2", 1'b0, 4'd0, 32'd0, 3'd0);

        // Dual push into empty queue: ALU entry retires first.
        drive(1'b1, 4'd1, 32'hA, 1'b1, 4'd2, 32'hB);
        chk("dual.mem_rdy", {31'd0, bus.mem_ready_o}, 32'd1);
        step(); idle();
        chk_wb("dual.r1", 1'b1, 4'd1, 32'hA, 3'd2);
        step();
        chk_wb("dual.r2", 1'b1, 4'd2, 32'hB, 3'd1);
        step();
        chk_wb("dual.empty", 1'b0, 4'd0, 32'd0, 3'd0);

        // Same rd from both sources: two write-backs, load value last.
        drive(1'b1, 4'd7, 32'h1, 1'b1, 4'd7, 32'h2);
        step(); idle();
        chk_wb("coll.a", 1'b1, 4'd7, 32'h1, 3'd2);
        step();
        chk_wb("coll.m", 1'b1, 4'd7, 32'h2, 3'd1);
        step();

        // Near-full boundary. With one pop every non-empty cycle, occupancy
        // peaks at DEPTH-1: free=1 is the tightest state producers can see.
        drive(1'b1, 4'd3, 32'h30, 1'b1, 4'd4, 32'h40);
        step();
        chk_wb("full.e1", 1'b1, 4'd3, 32'h30, 3'd2);
        drive(1'b1, 4'd5, 32'h50, 1'b1, 4'd6, 32'h60);
        chk("full.free2.mem_rdy", {31'd0, bus.mem_ready_o}, 32'd1);
        step();
        chk_wb("full.e2", 1'b1, 4'd4, 32'h40, 3'd3);
        drive(1'b1, 4'd8, 32'h80, 1'b1, 4'd9, 32'h90);
        chk("full.free1.alu_rdy", {31'd0, bus.alu_ready_o}, 32'd1);
        chk("full.free1.mem_rdy", {31'd0, bus.mem_ready_o}, 32'd0);
        step();
        chk_wb("full.e3", 1'b1, 4'd5, 32'h50, 3'd3);
        drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd9, 32'h90);
        chk("full.mem_only.rdy", {31'd0, bus.mem_ready_o}, 32'd1);
        step(); idle();
        chk_wb("full.e4", 1'b1, 4'd6, 32'h60, 3'd3);
        step();
        chk_wb("full.e5", 1'b1, 4'd8, 32'h80, 3'd2);
        step();
        chk_wb("full.e6", 1'b1, 4'd9, 32'h90, 3'd1);
        step();
        chk_wb("full.e7", 1'b0, 4'd0, 32'd0, 3'd0);

        // Wrap-around stream: 10 back-to-back ALU results retire in order.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 4'(i), 32'h100 + 32'(i), 1'b0, 4'd0, 32'd0);
            step();
            chk_wb($sformatf("wrap%0d", i), 1'b1, 4'(i), 32'h100 + 32'(i), 3'd1);
        end
        idle();
        step();
        chk_wb("wrap.end", 1'b0, 4'd0, 32'd0, 3'd0);

        // Reset mid-traffic with three entries queued.
        drive(1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h22);
        step();
        drive(1'b1, 4'd3, 32'h33, 1'b1, 4'd4, 32'h44);
        step(); idle();
        chk_wb("mid.pre", 1'b1, 4'd2, 32'h22, 3'd3);
        rst = 1'b0;
        #1;
        chk_wb("mid.rst", 1'b0, 4'd0, 32'd0, 3'd0);
        step();
        rst = 1'b1;
        drive(1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 32'd0);
        chk("mid.alu_rdy", {31'd0, bus.alu_ready_o}, 32'd1);
        chk("mid.mem_rdy", {31'd0, bus.mem_ready_o}, 32'd1);
        idle();
        step();
        chk_wb("mid.post", 1'b0, 4'd0, 32'd0, 3'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
